// File: rtl/btn_code_lock_ctrl.sv
// Two-button serial code lock: A enters 1, B enters 0; unlock window on match, timed lockout after MAX_FAIL misses.
// Optional code programming from OPEN (dual press) is compiled in when CODE_PROG_EN is defined.
module btn_code_lock_ctrl #(
  parameter int                  CODE_LEN      = 4,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE  = 4'b1011,
  parameter int                  MAX_FAIL      = 3,
  parameter int                  OPEN_CYCLES   = 1000,
  parameter int                  LOCK_CYCLES   = 5000,
  parameter int                  ENTRY_TIMEOUT = 2000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                A,
  input  logic                B,
  output logic [CODE_LEN-1:0] num,
  output logic [3:0]          digit_cnt,
  output logic                unlocked,
  output logic                locked_out,
  output logic                fail_pulse,
  output logic [2:0]          fail_cnt,
  output logic                prog_active
);

  localparam int TMR_MAX_OL = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TMR_MAX    = (TMR_MAX_OL > ENTRY_TIMEOUT) ? TMR_MAX_OL : ENTRY_TIMEOUT;
  localparam int TMR_W      = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0]    OPEN_LD  = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0]    LOCK_LD  = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0]    TO_LD    = TMR_W'(ENTRY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]    TMR_ZERO = TMR_W'(0);
  localparam logic [TMR_W-1:0]    TMR_ONE  = TMR_W'(1);
  localparam logic [3:0]          LEN4     = 4'(CODE_LEN);
  localparam logic [2:0]          MAX3     = 3'(MAX_FAIL);
  localparam logic [CODE_LEN-1:0] NUM_ZERO = {CODE_LEN{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
`ifdef CODE_PROG_EN
    S_PROG    = 3'd5,
`endif
    S_LOCKOUT = 3'd4
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [TMR_W-1:0]    tmr_r, tmr_nxt_s;
  logic                a_meta_r, a_sync_r, a_prev_r;
  logic                b_meta_r, b_sync_r, b_prev_r;
  logic [CODE_LEN-1:0] num_nxt_s, shifted_s, code_s;
  logic [3:0]          digit_nxt_s, digit_inc_s;
  logic [2:0]          fail_cnt_nxt_s, fail_inc_s;
  logic                fail_pulse_nxt_s;
  logic                press_a_s, press_b_s, dual_s, single_s;
`ifdef CODE_PROG_EN
  logic [CODE_LEN-1:0] code_r, code_nxt_s;
  assign code_s = code_r;
`else
  assign code_s = DEFAULT_CODE;
`endif

  // Edges come from the synchronized level, so a button held across a state change never re-fires.
  assign press_a_s   = a_sync_r & ~a_prev_r;
  assign press_b_s   = b_sync_r & ~b_prev_r;
  assign dual_s      = press_a_s & press_b_s;
  assign single_s    = (press_a_s | press_b_s) & ~dual_s;
  assign shifted_s   = {num[CODE_LEN-2:0], press_a_s};
  assign digit_inc_s = (digit_cnt == LEN4) ? digit_cnt : digit_cnt + 4'd1;
  assign fail_inc_s  = (fail_cnt == 3'd7) ? fail_cnt : fail_cnt + 3'd1;

  assign unlocked   = (state_r == S_OPEN);
  assign locked_out = (state_r == S_LOCKOUT);
`ifdef CODE_PROG_EN
  assign prog_active = (state_r == S_PROG);
`else
  assign prog_active = 1'b0;
`endif

  // Next-state and datapath decode; the shared timer is reloaded whenever a timed state is entered.
  always_comb begin
    state_nxt_s      = state_r;
    tmr_nxt_s        = tmr_r;
    num_nxt_s        = num;
    digit_nxt_s      = digit_cnt;
    fail_cnt_nxt_s   = fail_cnt;
    fail_pulse_nxt_s = 1'b0;
`ifdef CODE_PROG_EN
    code_nxt_s       = code_r;
`endif
    case (state_r)
      S_IDLE: begin
        num_nxt_s   = NUM_ZERO;
        digit_nxt_s = 4'd0;
        if (single_s) begin
          num_nxt_s   = {NUM_ZERO[CODE_LEN-2:0], press_a_s};
          digit_nxt_s = 4'd1;
          tmr_nxt_s   = TO_LD;
          state_nxt_s = S_ENTRY;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ENTRY: begin
        if (single_s) begin
          num_nxt_s   = shifted_s;
          digit_nxt_s = digit_inc_s;
          tmr_nxt_s   = TO_LD;
          if (digit_inc_s == LEN4) begin
            state_nxt_s = S_CHECK;
          end else begin
            state_nxt_s = S_ENTRY;
          end
        end else if (tmr_r == TMR_ZERO) begin
          state_nxt_s = S_IDLE;
          num_nxt_s   = NUM_ZERO;
          digit_nxt_s = 4'd0;
        end else begin
          tmr_nxt_s = tmr_r - TMR_ONE;
        end
      end
      S_CHECK: begin
        if (num == code_s) begin
          state_nxt_s    = S_OPEN;
          fail_cnt_nxt_s = 3'd0;
          tmr_nxt_s      = OPEN_LD;
        end else begin
          fail_pulse_nxt_s = 1'b1;
          fail_cnt_nxt_s   = fail_inc_s;
          num_nxt_s        = NUM_ZERO;
          digit_nxt_s      = 4'd0;
          if (fail_inc_s == MAX3) begin
            state_nxt_s = S_LOCKOUT;
            tmr_nxt_s   = LOCK_LD;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
      end
      S_OPEN: begin
`ifdef CODE_PROG_EN
        if (dual_s) begin
          state_nxt_s = S_PROG;
          num_nxt_s   = NUM_ZERO;
          digit_nxt_s = 4'd0;
          tmr_nxt_s   = TO_LD;
        end else
`endif
        if (tmr_r == TMR_ZERO) begin
          state_nxt_s = S_IDLE;
          num_nxt_s   = NUM_ZERO;
          digit_nxt_s = 4'd0;
        end else begin
          tmr_nxt_s = tmr_r - TMR_ONE;
        end
      end
      S_LOCKOUT: begin
        if (tmr_r == TMR_ZERO) begin
          state_nxt_s    = S_IDLE;
          fail_cnt_nxt_s = 3'd0;
          num_nxt_s      = NUM_ZERO;
          digit_nxt_s    = 4'd0;
        end else begin
          tmr_nxt_s = tmr_r - TMR_ONE;
        end
      end
`ifdef CODE_PROG_EN
      S_PROG: begin
        if (single_s) begin
          num_nxt_s   = shifted_s;
          digit_nxt_s = digit_inc_s;
          tmr_nxt_s   = TO_LD;
          if (digit_inc_s == LEN4) begin
            code_nxt_s  = shifted_s;
            state_nxt_s = S_IDLE;
            num_nxt_s   = NUM_ZERO;
            digit_nxt_s = 4'd0;
          end else begin
            state_nxt_s = S_PROG;
          end
        end else if (tmr_r == TMR_ZERO) begin
          state_nxt_s = S_IDLE;
          num_nxt_s   = NUM_ZERO;
          digit_nxt_s = 4'd0;
        end else begin
          tmr_nxt_s = tmr_r - TMR_ONE;
        end
      end
`endif
      default: begin
        state_nxt_s = S_IDLE;
        num_nxt_s   = NUM_ZERO;
        digit_nxt_s = 4'd0;
        tmr_nxt_s   = TMR_ZERO;
      end
    endcase
  end

  // Input synchronizers, edge-detect history and all state/output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_meta_r   <= 1'b0;
      a_sync_r   <= 1'b0;
      a_prev_r   <= 1'b0;
      b_meta_r   <= 1'b0;
      b_sync_r   <= 1'b0;
      b_prev_r   <= 1'b0;
      state_r    <= S_IDLE;
      tmr_r      <= TMR_ZERO;
      num        <= NUM_ZERO;
      digit_cnt  <= 4'd0;
      fail_cnt   <= 3'd0;
      fail_pulse <= 1'b0;
`ifdef CODE_PROG_EN
      code_r     <= DEFAULT_CODE;
`endif
    end else begin
      a_meta_r   <= A;
      a_sync_r   <= a_meta_r;
      a_prev_r   <= a_sync_r;
      b_meta_r   <= B;
      b_sync_r   <= b_meta_r;
      b_prev_r   <= b_sync_r;
      state_r    <= state_nxt_s;
      tmr_r      <= tmr_nxt_s;
      num        <= num_nxt_s;
      digit_cnt  <= digit_nxt_s;
      fail_cnt   <= fail_cnt_nxt_s;
      fail_pulse <= fail_pulse_nxt_s;
`ifdef CODE_PROG_EN
      code_r     <= code_nxt_s;
`endif
    end
  end

endmodule

// File: tb/tb_btn_code_lock_ctrl.sv
// Table-driven bench for btn_code_lock_ctrl (OPEN=20, LOCK=50, TIMEOUT=30); PROG vectors under CODE_PROG_EN.
module tb_btn_code_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       A = 1'b0;
  logic       B = 1'b0;
  logic [3:0] num;
  logic [3:0] digit_cnt;
  logic       unlocked, locked_out, fail_pulse, prog_active;
  logic [2:0] fail_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  btn_code_lock_ctrl #(
    .CODE_LEN(4), .DEFAULT_CODE(4'b1011), .MAX_FAIL(3),
    .OPEN_CYCLES(20), .LOCK_CYCLES(50), .ENTRY_TIMEOUT(30)
  ) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .num(num), .digit_cnt(digit_cnt),
    .unlocked(unlocked), .locked_out(locked_out), .fail_pulse(fail_pulse),
    .fail_cnt(fail_cnt), .prog_active(prog_active)
  );

  typedef struct {
    logic       a;
    logic       b;
    int         cyc;
    logic [3:0] num;
    logic [3:0] dig;
    logic       unl;
    logic       lck;
    logic [2:0] fc;
    logic       fp;
    logic       prog;
  } vec_t;

  vec_t vq[$];

  function automatic void v(input logic a, input logic b, input int cyc,
                            input logic [3:0] num_e, input logic [3:0] dig_e,
                            input logic unl, input logic lck, input logic [2:0] fc,
                            input logic fp, input logic prog);
    vec_t t;
    t.a = a; t.b = b; t.cyc = cyc; t.num = num_e; t.dig = dig_e;
    t.unl = unl; t.lck = lck; t.fc = fc; t.fp = fp; t.prog = prog;
    vq.push_back(t);
  endfunction

  // Four spaced presses; the last is held 3 cycles so the check lands on the CHECK (or PROG-exit) cycle.
  function automatic void code_vecs(input logic [3:0] code, input logic [2:0] fc, input logic prog);
    logic [3:0] acc;
    logic       bt;
    acc = 4'd0;
    for (int i = 0; i < 4; i++) begin
      bt  = code[3-i];
      acc = {acc[2:0], bt};
      if (i == 3) begin
        if (prog) v(bt, !bt, 3, 4'd0, 4'd0, 1'b0, 1'b0, fc, 1'b0, 1'b0);
        else      v(bt, !bt, 3, acc, 4'd4, 1'b0, 1'b0, fc, 1'b0, 1'b0);
      end else begin
        v(bt, !bt, 5, acc, 4'(i + 1), 1'b0, 1'b0, fc, 1'b0, prog);
        v(1'b0, 1'b0, 5, acc, 4'(i + 1), 1'b0, 1'b0, fc, 1'b0, prog);
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input int i, input vec_t e);
    chk($sformatf("v%0d.num", i), num, e.num);
    chk($sformatf("v%0d.digit_cnt", i), digit_cnt, e.dig);
    chk($sformatf("v%0d.unlocked", i), unlocked, e.unl);
    chk($sformatf("v%0d.locked_out", i), locked_out, e.lck);
    chk($sformatf("v%0d.fail_cnt", i), fail_cnt, e.fc);
    chk($sformatf("v%0d.fail_pulse", i), fail_pulse, e.fp);
    chk($sformatf("v%0d.prog_active", i), prog_active, e.prog);
  endtask

  task automatic press(input logic a, input logic b);
    A = a; B = b;
    repeat (5) @(posedge clk);
    @(negedge clk);
    A = 1'b0; B = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    // T1: correct code, exact OPEN window
    code_vecs(4'b1011, 3'd0, 1'b0);
    v(1, 0, 1,  4'b1011, 4'd4, 1, 0, 3'd0, 0, 0);
    v(0, 0, 18, 4'b1011, 4'd4, 1, 0, 3'd0, 0, 0);
    v(0, 0, 1,  4'b1011, 4'd4, 1, 0, 3'd0, 0, 0);
    v(0, 0, 1,  4'd0,    4'd0, 0, 0, 3'd0, 0, 0);
    // T2: three wrong attempts, lockout, presses ignored, A held across exit
    for (int k = 0; k < 3; k++) begin
      code_vecs(4'b0000, 3'(k), 1'b0);
      v(0, 1, 1, 4'd0, 4'd0, 0, (k == 2), 3'(k + 1), 1, 0);
      if (k < 2) v(0, 0, 5, 4'd0, 4'd0, 0, 0, 3'(k + 1), 0, 0);
    end
    v(0, 0, 5,  4'd0, 4'd0, 0, 1, 3'd3, 0, 0);
    v(1, 0, 5,  4'd0, 4'd0, 0, 1, 3'd3, 0, 0);
    v(0, 0, 5,  4'd0, 4'd0, 0, 1, 3'd3, 0, 0);
    v(0, 1, 5,  4'd0, 4'd0, 0, 1, 3'd3, 0, 0);
    v(0, 0, 5,  4'd0, 4'd0, 0, 1, 3'd3, 0, 0);
    v(1, 0, 23, 4'd0, 4'd0, 0, 1, 3'd3, 0, 0);
    v(1, 0, 1,  4'd0, 4'd0, 0, 1, 3'd3, 0, 0);
    v(1, 0, 1,  4'd0, 4'd0, 0, 0, 3'd0, 0, 0);
    v(1, 0, 5,  4'd0, 4'd0, 0, 0, 3'd0, 0, 0);
    v(0, 0, 5,  4'd0, 4'd0, 0, 0, 3'd0, 0, 0);
    // T3: one wrong, then correct clears fail_cnt
    code_vecs(4'b0000, 3'd0, 1'b0);
    v(0, 1, 1,  4'd0, 4'd0, 0, 0, 3'd1, 1, 0);
    v(0, 0, 5,  4'd0, 4'd0, 0, 0, 3'd1, 0, 0);
    code_vecs(4'b1011, 3'd1, 1'b0);
    v(1, 0, 1,  4'b1011, 4'd4, 1, 0, 3'd0, 0, 0);
    v(0, 0, 20, 4'd0, 4'd0, 0, 0, 3'd0, 0, 0);
    // T4: two presses then entry timeout, fail_cnt kept
    code_vecs(4'b0000, 3'd0, 1'b0);
    v(0, 1, 1,  4'd0, 4'd0, 0, 0, 3'd1, 1, 0);
    v(0, 0, 5,  4'd0, 4'd0, 0, 0, 3'd1, 0, 0);
    v(1, 0, 5,  4'd1, 4'd1, 0, 0, 3'd1, 0, 0);
    v(0, 0, 5,  4'd1, 4'd1, 0, 0, 3'd1, 0, 0);
    v(1, 0, 5,  4'd3, 4'd2, 0, 0, 3'd1, 0, 0);
    v(0, 0, 27, 4'd3, 4'd2, 0, 0, 3'd1, 0, 0);
    v(0, 0, 1,  4'd0, 4'd0, 0, 0, 3'd1, 0, 0);
    // T5: dual press in ENTRY and IDLE ignored, dual does not reload timeout
    v(1, 0, 5,  4'd1, 4'd1, 0, 0, 3'd1, 0, 0);
    v(0, 0, 5,  4'd1, 4'd1, 0, 0, 3'd1, 0, 0);
    v(1, 1, 5,  4'd1, 4'd1, 0, 0, 3'd1, 0, 0);
    v(0, 0, 5,  4'd1, 4'd1, 0, 0, 3'd1, 0, 0);
    v(0, 1, 5,  4'd2, 4'd2, 0, 0, 3'd1, 0, 0);
    v(0, 0, 5,  4'd2, 4'd2, 0, 0, 3'd1, 0, 0);
    v(0, 0, 22, 4'd2, 4'd2, 0, 0, 3'd1, 0, 0);
    v(0, 0, 1,  4'd0, 4'd0, 0, 0, 3'd1, 0, 0);
    v(1, 1, 5,  4'd0, 4'd0, 0, 0, 3'd1, 0, 0);
    v(0, 0, 5,  4'd0, 4'd0, 0, 0, 3'd1, 0, 0);
    // T6: dual press in OPEN
    code_vecs(4'b1011, 3'd1, 1'b0);
    v(1, 0, 1,  4'b1011, 4'd4, 1, 0, 3'd0, 0, 0);
    v(0, 0, 4,  4'b1011, 4'd4, 1, 0, 3'd0, 0, 0);
`ifdef CODE_PROG_EN
    v(1, 1, 4,  4'd0, 4'd0, 0, 0, 3'd0, 0, 1);
    v(0, 0, 5,  4'd0, 4'd0, 0, 0, 3'd0, 0, 1);
    code_vecs(4'b0101, 3'd0, 1'b1);
    v(0, 0, 5,  4'd0, 4'd0, 0, 0, 3'd0, 0, 0);
    code_vecs(4'b1011, 3'd0, 1'b0);
    v(1, 0, 1,  4'd0, 4'd0, 0, 0, 3'd1, 1, 0);
    v(0, 0, 5,  4'd0, 4'd0, 0, 0, 3'd1, 0, 0);
    code_vecs(4'b0101, 3'd1, 1'b0);
    v(1, 0, 1,  4'b0101, 4'd4, 1, 0, 3'd0, 0, 0);
    v(0, 0, 20, 4'd0, 4'd0, 0, 0, 3'd0, 0, 0);
`else
    v(1, 1, 4,  4'b1011, 4'd4, 1, 0, 3'd0, 0, 0);
    v(0, 0, 11, 4'b1011, 4'd4, 1, 0, 3'd0, 0, 0);
    v(0, 0, 1,  4'd0, 4'd0, 0, 0, 3'd0, 0, 0);
`endif
    code_vecs(4'b0000, 3'd0, 1'b0);
    v(0, 1, 1,  4'd0, 4'd0, 0, 0, 3'd1, 1, 0);
    v(0, 0, 5,  4'd0, 4'd0, 0, 0, 3'd1, 0, 0);

    // Reset state, checked while asserted and after release
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.num", num, 0);
    chk("rst.unlocked", unlocked, 0);
    chk("rst.fail_cnt", fail_cnt, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rel.num", num, 0);
    chk("rel.digit_cnt", digit_cnt, 0);
    chk("rel.locked_out", locked_out, 0);
    chk("rel.fail_pulse", fail_pulse, 0);
    chk("rel.prog_active", prog_active, 0);

    for (int i = 0; i < vq.size(); i++) begin
      A = vq[i].a;
      B = vq[i].b;
      repeat (vq[i].cyc) @(posedge clk);
      @(negedge clk);
      chk_vec(i, vq[i]);
    end

    // Async reset mid-attempt clears immediately
    A = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst.num", num, 1);
    A = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.num", num, 0);
    chk("mid_rst.digit_cnt", digit_cnt, 0);
    chk("mid_rst.fail_cnt", fail_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Default code after reset, with bounded wait for unlock latency
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    A = 1'b1;
    lat = 0;
    while (!unlocked && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("unlock_latency", lat, 4);
    chk("unlock.num", num, 4'b1011);
    A = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("open_rst.unlocked", unlocked, 0);
    chk("open_rst.num", num, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
